master_tx_ltssm: RTL and testbench
==================================

# master_tx_ltssm

Transmit-side companion to the receive LTSSM checker. For each substate requested by the main LTSSM, it drives the ordered-set type (TS1, TS2 or Idle data) and the PAD/number field selects into the TX ordered-set generator. It counts the ordered sets the generator accepts and combines that count with the RX-side completion pulse. When the transmit requirements of the substate are met, it raises `finish` to the main LTSSM.

## Interface
Parameters:
- POLL_ACTIVE_TS, 1024, minimum TS1 sent in Polling.Active before finish
- POST_RX_COUNT, 16, ordered sets sent after the RX condition in Polling.Configuration, Configuration.Complete and Configuration.Idle
- CONFIG_MIN_TS, 1, minimum TS1 sent in Configuration.LinkWidth*/Lanenum* substates

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- substate  in  4  substate code: 0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration, 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle, 10 L0
- restart  in  1  one-cycle pulse; treat the current substate as a new request
- rxDone  in  1  one-cycle pulse; the RX checker has met its condition
- osAck  in  1  the generator consumed the presented ordered set
- osValid  out  1  an ordered set request is presented
- osType  out  2  00 none, 01 TS1, 10 TS2, 11 Idle data
- padLink  out  1  link-number field = PAD
- padLane  out  1  lane-number field = PAD
- txElectricalIdle  out  1  hold transmitters in electrical idle
- sentCount  out  11  ordered sets acknowledged in the current request; saturates at 2047
- finish  out  1  one-cycle completion pulse

## Operation
- Reset values: osValid=0, osType=00, padLink=0, padLane=0, sentCount=0, finish=0, txElectricalIdle=1. Internal: lastSubstate=4'hF, rxSeen=0, postRxCnt=0, state=IDLE.
- All outputs are registered.
- FSM states: IDLE, SEND, DRAIN, DONE.
- IDLE: a new request exists when `substate != lastSubstate` or `restart` is high. On acceptance, lastSubstate ← substate and sentCount, rxSeen and postRxCnt are cleared.
  - Substates 0 and 1: txElectricalIdle=1 → DONE.
  - Substate 10 (L0): txElectricalIdle=0, osValid=0, stay in IDLE, no finish.
  - Substates 2–9: txElectricalIdle=0, osValid=1 → SEND.
  - Codes 11–15: ignored; lastSubstate is updated, no other action.
- Ordered-set mapping:
  - 2: TS1, padLink=1, padLane=1.
  - 3: TS2, padLink=1, padLane=1.
  - 4, 5: TS1, padLink=0, padLane=1.
  - 6, 7: TS1, padLink=0, padLane=0.
  - 8: TS2, padLink=0, padLane=0.
  - 9: Idle data, padLink=0, padLane=0.
- Handshake: osType, padLink and padLane are stable while osValid=1. A transfer occurs on each cycle with osValid && osAck, and back-to-back acks are legal.
- SEND:
  - Each transfer increments sentCount (saturating). rxDone sets rxSeen.
  - Let rxOK = rxSeen || rxDone.
  - Substates 3, 8, 9: when rxOK → DRAIN. A transfer in that same cycle counts toward sentCount only.
  - Substate 2: when rxOK and (sentCount including this cycle's transfer) ≥ POLL_ACTIVE_TS → DONE.
  - Substates 4–7: same rule with CONFIG_MIN_TS.
- DRAIN: each transfer increments both postRxCnt and sentCount. The transfer that brings postRxCnt to POST_RX_COUNT → DONE.
- DONE: finish=1 and osValid=0 for exactly one cycle → IDLE. The main LTSSM is responsible for changing substate; rxDone has no effect outside SEND.
- Abort: in SEND or DRAIN, a substate change or restart → IDLE with osValid=0 and no finish. A transfer in the abort cycle is discarded. The new request is accepted from IDLE on the following cycle.
- A substate change during DONE does not suppress finish.
- In IDLE after completion, the substate is unchanged, so there is no re-request until restart.

## Timing
- Request accepted at edge E (substate first differs in cycle E-1): osValid=1 from cycle E, one cycle of latency.
- Detect substates: finish is high in cycle E; txElectricalIdle=1 throughout.
- Completion: the final qualifying transfer in cycle N gives osValid=0 and finish=1 in cycle N+1, and finish=0 in N+2.
- Abort latency: osValid drops one cycle after the substate change. The new request's osValid rises two cycles after the change.
- sentCount updates the cycle after each transfer.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately.

## Test plan
- Reset: assert reset mid-SEND → osValid=0, finish=0, txElectricalIdle=1, sentCount=0 immediately; after release, substate=0 → finish pulses 1 cycle, no osValid.
- Polling.Active: substate=2, osAck held high, rxDone at transfer 100 → TS1 with padLink=padLane=1; finish one cycle after transfer 1024; sentCount=1024.
- Polling.Active without rxDone: 2047+ acks → no finish, sentCount stays at 2047; rxDone then → finish next edge.
- Configuration.Complete with osAck toggling every other cycle: rxDone after 5 transfers → exactly 16 further transfers, then finish; osType=10, padLink=padLane=0; sentCount=21.
- Abort: substate=3, after rxDone and 7 drain transfers switch to 0 → osValid=0 next cycle, no finish; detect finish follows 2 cycles after the switch.
- L0: substate=10 → txElectricalIdle=0, osValid=0, no finish for 100 cycles. substate=9 with restart → new Idle-data request; rxDone then 16 transfers → finish.

Source files
------------

// File: rtl/master_tx_ltssm.sv
// TX-side LTSSM helper: selects the ordered set per substate, counts generator acks, pulses finish.
// Outputs are registered (one-cycle latency); osValid is held until the generator acks with osAck.
module master_tx_ltssm #(
  parameter int POLL_ACTIVE_TS = 1024,
  parameter int POST_RX_COUNT  = 16,
  parameter int CONFIG_MIN_TS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  substate,
  input  logic        restart,
  input  logic        rxDone,
  input  logic        osAck,
  output logic        osValid,
  output logic [1:0]  osType,
  output logic        padLink,
  output logic        padLane,
  output logic        txElectricalIdle,
  output logic [10:0] sentCount,
  output logic        finish
);

  localparam logic [10:0] PollTh = 11'(POLL_ACTIVE_TS);
  localparam logic [10:0] CfgTh  = 11'(CONFIG_MIN_TS);
  localparam logic [10:0] PostTh = 11'(POST_RX_COUNT);

  localparam logic [1:0] OsTs1  = 2'b01;
  localparam logic [1:0] OsTs2  = 2'b10;
  localparam logic [1:0] OsIdle = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t      state, stateN;
  logic [3:0]  lastSubstate, lastSubstateN;
  logic        rxSeen, rxSeenN;
  logic [10:0] postRxCnt, postRxCntN;
  logic [10:0] sentCountN, sentInc;
  logic        osValidN, padLinkN, padLaneN, txElectricalIdleN, finishN;
  logic [1:0]  osTypeN;
  logic        newReq, xfer, rxOK;

  assign newReq  = (substate != lastSubstate) || restart;
  assign xfer    = osValid && osAck;
  assign rxOK    = rxSeen || rxDone;
  assign sentInc = (xfer && (sentCount != 11'h7FF)) ? sentCount + 11'd1 : sentCount;

  always_comb begin
    stateN            = state;
    lastSubstateN     = lastSubstate;
    rxSeenN           = rxSeen;
    postRxCntN        = postRxCnt;
    sentCountN        = sentCount;
    osValidN          = osValid;
    osTypeN           = osType;
    padLinkN          = padLink;
    padLaneN          = padLane;
    txElectricalIdleN = txElectricalIdle;
    finishN           = 1'b0;

    case (state)
      IDLE: begin
        if (newReq) begin
          lastSubstateN = substate;
          sentCountN    = '0;
          rxSeenN       = 1'b0;
          postRxCntN    = '0;
          case (substate)
            4'd0, 4'd1: begin
              txElectricalIdleN = 1'b1;
              finishN           = 1'b1;
              stateN            = DONE;
            end
            4'd10: begin
              txElectricalIdleN = 1'b0;
              osValidN          = 1'b0;
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
              txElectricalIdleN = 1'b0;
              osValidN          = 1'b1;
              stateN            = SEND;
              padLinkN          = (substate <= 4'd3);
              padLaneN          = (substate <= 4'd5);
              case (substate)
                4'd3, 4'd8: osTypeN = OsTs2;
                4'd9:       osTypeN = OsIdle;
                default:    osTypeN = OsTs1;
              endcase
            end
            default: ;
          endcase
        end
      end

      SEND: begin
        if (newReq) begin
          // Forget the accepted substate so a restart-triggered abort is re-accepted next cycle.
          stateN        = IDLE;
          osValidN      = 1'b0;
          lastSubstateN = 4'hF;
        end else begin
          sentCountN = sentInc;
          rxSeenN    = rxOK;
          case (lastSubstate)
            4'd3, 4'd8, 4'd9: begin
              if (rxOK) stateN = DRAIN;
            end
            4'd2: begin
              if (rxOK && (sentInc >= PollTh)) begin
                stateN   = DONE;
                osValidN = 1'b0;
                finishN  = 1'b1;
              end
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
              if (rxOK && (sentInc >= CfgTh)) begin
                stateN   = DONE;
                osValidN = 1'b0;
                finishN  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      DRAIN: begin
        if (newReq) begin
          stateN        = IDLE;
          osValidN      = 1'b0;
          lastSubstateN = 4'hF;
        end else if (xfer) begin
          postRxCntN = postRxCnt + 11'd1;
          sentCountN = sentInc;
          if ((postRxCnt + 11'd1) == PostTh) begin
            stateN   = DONE;
            osValidN = 1'b0;
            finishN  = 1'b1;
          end
        end
      end

      default: begin
        stateN = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      lastSubstate     <= 4'hF;
      rxSeen           <= 1'b0;
      postRxCnt        <= '0;
      sentCount        <= '0;
      osValid          <= 1'b0;
      osType           <= 2'b00;
      padLink          <= 1'b0;
      padLane          <= 1'b0;
      txElectricalIdle <= 1'b1;
      finish           <= 1'b0;
    end else begin
      state            <= stateN;
      lastSubstate     <= lastSubstateN;
      rxSeen           <= rxSeenN;
      postRxCnt        <= postRxCntN;
      sentCount        <= sentCountN;
      osValid          <= osValidN;
      osType           <= osTypeN;
      padLink          <= padLinkN;
      padLane          <= padLaneN;
      txElectricalIdle <= txElectricalIdleN;
      finish           <= finishN;
    end
  end

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Directed bench for master_tx_ltssm; expected values are hand-computed per step.
module tb_master_tx_ltssm;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  substate;
  logic        restart, rxDone, osAck;
  logic        osValid;
  logic [1:0]  osType;
  logic        padLink, padLane, txElectricalIdle, finish;
  logic [10:0] sentCount;

  int checks = 0;
  int failures = 0;
  logic sawFinish, sawValid;

  master_tx_ltssm dut (
    .clk(clk),
    .reset(reset),
    .substate(substate),
    .restart(restart),
    .rxDone(rxDone),
    .osAck(osAck),
    .osValid(osValid),
    .osType(osType),
    .padLink(padLink),
    .padLane(padLane),
    .txElectricalIdle(txElectricalIdle),
    .sentCount(sentCount),
    .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; substate = 4'hF; restart = 1'b0; rxDone = 1'b0; osAck = 1'b0;
    #12;
    check("rst_osValid", osValid, 0);
    check("rst_osType", osType, 0);
    check("rst_finish", finish, 0);
    check("rst_txEI", txElectricalIdle, 1);
    check("rst_sentCount", sentCount, 0);
    check("rst_pads", {padLink, padLane}, 0);
    reset = 1'b1;
    tick();
    check("ignored_code_idle", osValid, 0);

    // Reset in the middle of Polling.Active
    substate = 4'd2;
    tick();
    check("pa0_osValid", osValid, 1);
    check("pa0_osType", osType, 2'b01);
    check("pa0_pads", {padLink, padLane}, 2'b11);
    check("pa0_txEI", txElectricalIdle, 0);
    osAck = 1'b1;
    tick(); tick(); tick();
    check("pa0_sent3", sentCount, 3);
    #2 reset = 1'b0;
    #1;
    check("midrst_osValid", osValid, 0);
    check("midrst_finish", finish, 0);
    check("midrst_txEI", txElectricalIdle, 1);
    check("midrst_sentCount", sentCount, 0);
    reset = 1'b1; osAck = 1'b0; substate = 4'd0;
    tick();
    check("det_finish", finish, 1);
    check("det_osValid", osValid, 0);
    check("det_txEI", txElectricalIdle, 1);
    tick();
    check("det_finish_low", finish, 0);

    // Polling.Active with rxDone at transfer 100
    substate = 4'd2; osAck = 1'b1;
    tick();
    check("pa_sent0", sentCount, 0);
    for (int k = 1; k <= 1023; k++) begin
      rxDone = (k == 100);
      tick();
    end
    rxDone = 1'b0;
    check("pa_sent1023", sentCount, 1023);
    check("pa_nofinish1023", finish, 0);
    check("pa_valid1023", osValid, 1);
    tick();
    check("pa_finish", finish, 1);
    check("pa_valid_drop", osValid, 0);
    check("pa_sent1024", sentCount, 1024);
    tick();
    check("pa_finish_low", finish, 0);
    tick();
    check("pa_no_rerequest", osValid, 0);
    check("pa_sent_hold", sentCount, 1024);

    // Polling.Active without rxDone: saturation
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("sat_valid", osValid, 1);
    check("sat_sent0", sentCount, 0);
    sawFinish = 1'b0;
    for (int k = 0; k < 2100; k++) begin
      tick();
      sawFinish |= finish;
    end
    check("sat_nofinish", sawFinish, 0);
    check("sat_sent2047", sentCount, 2047);
    check("sat_valid_held", osValid, 1);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    check("sat_finish", finish, 1);
    check("sat_sent_after", sentCount, 2047);
    tick();
    check("sat_finish_low", finish, 0);

    // Configuration.Complete with toggling osAck
    substate = 4'd8; osAck = 1'b0;
    tick();
    check("cc_osType", osType, 2'b10);
    check("cc_pads", {padLink, padLane}, 2'b00);
    check("cc_valid", osValid, 1);
    for (int i = 0; i <= 40; i++) begin
      osAck = (i % 2 == 1);
      rxDone = (i == 10);
      tick();
    end
    rxDone = 1'b0;
    check("cc_sent20", sentCount, 20);
    check("cc_nofinish", finish, 0);
    osAck = 1'b1;
    tick();
    osAck = 1'b0;
    check("cc_finish", finish, 1);
    check("cc_sent21", sentCount, 21);
    check("cc_valid_drop", osValid, 0);
    tick();

    // Abort during Polling.Configuration drain
    substate = 4'd3; osAck = 1'b1;
    tick();
    check("ab_osType", osType, 2'b10);
    check("ab_pads", {padLink, padLane}, 2'b11);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("ab_sent8", sentCount, 8);
    substate = 4'd0;
    tick();
    check("ab_valid_drop", osValid, 0);
    check("ab_nofinish", finish, 0);
    check("ab_sent_discard", sentCount, 8);
    tick();
    check("ab_det_finish", finish, 1);
    check("ab_det_txEI", txElectricalIdle, 1);
    tick();
    check("ab_det_finish_low", finish, 0);

    // L0 then Configuration.Idle via restart
    substate = 4'd10; osAck = 1'b0;
    tick();
    check("l0_txEI", txElectricalIdle, 0);
    sawFinish = 1'b0; sawValid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      sawFinish |= finish;
      sawValid  |= osValid;
    end
    check("l0_nofinish", sawFinish, 0);
    check("l0_novalid", sawValid, 0);
    substate = 4'd9; restart = 1'b1;
    tick();
    restart = 1'b0;
    check("ci_valid", osValid, 1);
    check("ci_osType", osType, 2'b11);
    check("ci_pads", {padLink, padLane}, 2'b00);
    rxDone = 1'b1; osAck = 1'b1;
    tick();
    rxDone = 1'b0;
    check("ci_sent1", sentCount, 1);
    for (int i = 0; i < 15; i++) tick();
    check("ci_sent16", sentCount, 16);
    check("ci_nofinish", finish, 0);
    tick();
    check("ci_finish", finish, 1);
    check("ci_sent17", sentCount, 17);
    tick();
    check("ci_finish_low", finish, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
